cdc_event_arbiter: RTL and testbench

//  Collects NCH asynchronous slow-domain event signals into the clk domain.

---
 rtl/cdc_event_arbiter_pkg.sv | 15 +
 rtl/cdc_event_arbiter_edge_sync.sv | 36 +++
 rtl/cdc_event_arbiter.sv | 169 ++++++++++++++++
 tb/tb_cdc_event_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_event_arbiter_pkg.sv
// Shared types and helpers for the CDC event arbiter.
package cdc_evt_pkg;

    // Arbiter FSM: IDLE waits for pending work, OFFER holds an event on the port.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

    // Width of a channel id; a single channel still needs one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdc_event_arbiter_edge_sync.sv
// One channel: multi-flop synchronizer followed by a rising-edge detector.
module cdc_edge_sync
    import cdc_evt_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;

    // Shift the asynchronous level through the synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

    // Remember the previous synchronized level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_q <= 1'b0;
        end else begin
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/cdc_event_arbiter.sv
// Synchronizes NCH async event lines, counts pending events per channel and
// serializes them round-robin onto one valid/ready port carrying the channel id.
module cdc_event_arbiter
    import cdc_evt_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int CNT_W       = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         sig_async,
    input  logic                   enable,
    output logic                   evt_valid,
    output logic [id_w(NCH)-1:0]   evt_id,
    input  logic                   evt_ready,
    output logic [NCH-1:0]         ovf,
    input  logic [NCH-1:0]         ovf_clr
);

    localparam int               ID_W     = id_w(NCH);
    localparam int               ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [NCH-1:0]   rise;
    logic [ARM_W-1:0] arm_q;
    logic             armed;
    logic             hs;
    logic [NCH-1:0]   inc_v, dec_v, zero_v, ovf_set, eff_req;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic [NCH-1:0]   ovf_q, ovf_d;
    logic [ID_W-1:0]  ptr, pick;
    logic [ID_W-1:0]  rr_q, rr_d, evt_id_q, evt_id_d;
    logic             evt_valid_q, evt_valid_d;
    arb_state_t       state_q, state_d;

    for (genvar g = 0; g < NCH; g++) begin : g_sync
        cdc_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk     (clk),
            .rst     (rst),
            .async_i (sig_async[g]),
            .rise_o  (rise[g])
        );
    end

    // Hold off edge detection until the synchronizers have flushed after reset,
    // so a level that is already high at release is not mistaken for an event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm_q <= '0;
        end else if (!armed) begin
            arm_q <= arm_q + ARM_W'(1);
        end
    end

    assign armed = (arm_q == ARM_DONE);
    assign hs    = evt_valid_q & evt_ready;

    // Pending counters: saturate at max, flag overflow, and derive the
    // effective request vector seen by this cycle's arbitration.
    always_comb begin
        inc_v   = '0;
        dec_v   = '0;
        zero_v  = '0;
        ovf_set = '0;
        eff_req = '0;
        for (int i = 0; i < NCH; i++) begin
            inc_v[i]  = rise[i] & armed;
            dec_v[i]  = hs && (evt_id_q == ID_W'(i));
            zero_v[i] = (cnt_q[i] == '0);
            cnt_d[i]  = cnt_q[i];
            if (inc_v[i] && !dec_v[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_set[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else if (dec_v[i] && !inc_v[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
            eff_req[i] = dec_v[i] ? (cnt_q[i] > CNT_W'(1)) : !zero_v[i];
        end
        ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
    end

    // Round-robin pick: rotate the doubled request vector so the search
    // starts just after the pointer, then take the lowest set bit.
    always_comb begin
        logic [2*NCH-1:0] dbl;
        int               off;
        int               pick_int;
        ptr      = hs ? evt_id_q : rr_q;
        dbl      = {eff_req, eff_req} >> (int'(ptr) + 1);
        off      = 0;
        for (int j = 2*NCH-1; j >= 0; j--) begin
            if (dbl[j]) begin
                off = j;
            end
        end
        pick_int = int'(ptr) + 1 + off;
        if (pick_int >= NCH) pick_int = pick_int - NCH;
        if (pick_int >= NCH) pick_int = pick_int - NCH;
        pick = ID_W'(pick_int);
    end

    // Offer FSM: start offers only when enabled, never retract an offer,
    // and re-arbitrate on the handshake cycle for back-to-back events.
    always_comb begin
        state_d     = state_q;
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        rr_d        = rr_q;
        case (state_q)
            IDLE: begin
                if (enable && (|eff_req)) begin
                    evt_id_d    = pick;
                    evt_valid_d = 1'b1;
                    state_d     = OFFER;
                end else begin
                    evt_valid_d = 1'b0;
                end
            end
            OFFER: begin
                if (hs) begin
                    rr_d = evt_id_q;
                    if (enable && (|eff_req)) begin
                        evt_id_d = pick;
                    end else begin
                        evt_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                evt_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State, counters, overflow flags and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
            ovf_q       <= '0;
            state_q     <= IDLE;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            rr_q        <= ID_W'(NCH - 1);
        end else begin
            for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            rr_q        <= rr_d;
        end
    end

    // A grant can only be issued for a channel that has something pending.
    assert property (@(posedge clk) disable iff (rst) ((dec_v & zero_v) == '0));

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cdc_event_arbiter.sv
// Directed testbench for cdc_event_arbiter (NCH=4, CNT_W=3, SYNC_STAGES=2).
module tb_cdc_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sig_async;
    logic       enable;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_ready;
    logic [3:0] ovf;
    logic [3:0] ovf_clr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cdc_event_arbiter #(.NCH(4), .CNT_W(3), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_async (sig_async),
        .enable    (enable),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_ready (evt_ready),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b1; sig_async = 4'b0; enable = 1'b1; evt_ready = 1'b0; ovf_clr = 4'b0;
        tick(2);
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_reset();
        rst = 1'b1; sig_async = 4'b1111; enable = 1'b1; evt_ready = 1'b1; ovf_clr = 4'b0;
        tick(3);
        n_cmp++;
        if (evt_valid !== 1'b0 || evt_id !== 2'd0 || ovf !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%b id=%0d ovf=%b, want 0/0/0000", evt_valid, evt_id, ovf);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            n_cmp++;
            if (evt_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_level_high_no_event cyc%0d: got valid=%b want 0", i, evt_valid);
            end
        end
        sig_async = 4'b0;
        tick(6);
        n_cmp++;
        if (evt_valid !== 1'b0 || ovf !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_falling_no_event: got valid=%b ovf=%b want 0/0000", evt_valid, ovf);
        end
    endtask

    task automatic test_single_event();
        reset_dut();
        evt_ready = 1'b1;
        sig_async = 4'b0100;
        tick(3);
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_early: got valid=%b want 0", evt_valid);
        end
        tick(1);
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
            n_bad++;
            $display("FAIL single_offer: got valid=%b id=%0d want 1/2", evt_valid, evt_id);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1);
            n_cmp++;
            if (evt_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL single_idle cyc%0d: got valid=%b want 0", i, evt_valid);
            end
        end
        sig_async = 4'b0;
        tick(4);
    endtask

    task automatic test_back_to_back();
        reset_dut();
        evt_ready = 1'b1;
        sig_async = 4'b1111;
        tick(3);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            n_cmp++;
            if (evt_valid !== 1'b1 || evt_id !== 2'(i)) begin
                n_bad++;
                $display("FAIL b2b_slot%0d: got valid=%b id=%0d want 1/%0d", i, evt_valid, evt_id, i);
            end
        end
        tick(1);
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_drain: got valid=%b want 0", evt_valid);
        end
        sig_async = 4'b0;
        tick(4);
    endtask

    task automatic test_overflow();
        int n;
        reset_dut();
        evt_ready = 1'b0;
        for (int p = 0; p < 7; p++) begin
            sig_async = 4'b0010; tick(2);
            sig_async = 4'b0000; tick(2);
        end
        n_cmp++;
        if (ovf !== 4'b0000 || evt_valid !== 1'b1 || evt_id !== 2'd1) begin
            n_bad++;
            $display("FAIL ovf_after7: got ovf=%b valid=%b id=%0d want 0000/1/1", ovf, evt_valid, evt_id);
        end
        sig_async = 4'b0010; tick(2);
        sig_async = 4'b0000; tick(2);
        n_cmp++;
        if (ovf !== 4'b0010) begin
            n_bad++;
            $display("FAIL ovf_after8: got ovf=%b want 0010", ovf);
        end
        // ninth event overflows again in the same cycle as the clear pulse
        sig_async = 4'b0010; tick(2);
        sig_async = 4'b0000; ovf_clr = 4'b0010; tick(1);
        ovf_clr = 4'b0000;
        n_cmp++;
        if (ovf !== 4'b0010) begin
            n_bad++;
            $display("FAIL ovf_set_beats_clr: got ovf=%b want 0010", ovf);
        end
        tick(1);
        ovf_clr = 4'b0010; tick(1);
        ovf_clr = 4'b0000;
        n_cmp++;
        if (ovf !== 4'b0000) begin
            n_bad++;
            $display("FAIL ovf_clear: got ovf=%b want 0000", ovf);
        end
        evt_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (evt_valid === 1'b1) begin
                n++;
                n_cmp++;
                if (evt_id !== 2'd1) begin
                    n_bad++;
                    $display("FAIL ovf_drain_id: got id=%0d want 1", evt_id);
                end
            end
            tick(1);
        end
        n_cmp++;
        if (n != 7) begin
            n_bad++;
            $display("FAIL ovf_drain_count: got %0d events want 7", n);
        end
    endtask

    task automatic test_fairness();
        int got [8];
        int exp_ids [5] = '{0, 3, 0, 0, 0};
        int k;
        reset_dut();
        evt_ready = 1'b0;
        for (int p = 0; p < 4; p++) begin
            sig_async = (p == 1) ? 4'b1001 : 4'b0001; tick(2);
            sig_async = 4'b0000; tick(2);
        end
        for (int i = 0; i < 8; i++) got[i] = -1;
        evt_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            if (evt_valid === 1'b1 && k < 8) begin
                got[k] = int'(evt_id);
                k++;
            end
            tick(1);
        end
        n_cmp++;
        if (k != 5) begin
            n_bad++;
            $display("FAIL fair_count: got %0d handshakes want 5", k);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (got[i] != exp_ids[i]) begin
                n_bad++;
                $display("FAIL fair_order%0d: got id=%0d want %0d", i, got[i], exp_ids[i]);
            end
        end
    endtask

    task automatic test_hold_enable();
        reset_dut();
        evt_ready = 1'b0;
        sig_async = 4'b0100; tick(2);
        sig_async = 4'b0000; tick(2);
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
            n_bad++;
            $display("FAIL hold_offer: got valid=%b id=%0d want 1/2", evt_valid, evt_id);
        end
        enable = 1'b0;
        sig_async = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (i == 1) sig_async = 4'b0000;
            n_cmp++;
            if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
                n_bad++;
                $display("FAIL hold_stable cyc%0d: got valid=%b id=%0d want 1/2", i, evt_valid, evt_id);
            end
        end
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (evt_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_disabled_idle cyc%0d: got valid=%b want 0", i, evt_valid);
            end
            tick(1);
        end
        enable = 1'b1;
        tick(1);
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
            n_bad++;
            $display("FAIL hold_reenable: got valid=%b id=%0d want 1/1", evt_valid, evt_id);
        end
        evt_ready = 1'b1;
        tick(1);
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_final_idle: got valid=%b want 0", evt_valid);
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        evt_ready = 1'b0;
        sig_async = 4'b1001; tick(2);
        sig_async = 4'b0000; tick(2);
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
            n_bad++;
            $display("FAIL areset_offer: got valid=%b id=%0d want 1/0", evt_valid, evt_id);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (evt_valid !== 1'b0 || evt_id !== 2'd0) begin
            n_bad++;
            $display("FAIL areset_async_drop: got valid=%b id=%0d want 0/0", evt_valid, evt_id);
        end
        @(negedge clk);
        rst = 1'b0;
        evt_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            n_cmp++;
            if (evt_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL areset_discard cyc%0d: got valid=%b want 0", i, evt_valid);
            end
        end
    endtask

    initial begin
        rst = 1'b1; sig_async = 4'b0; enable = 1'b1; evt_ready = 1'b0; ovf_clr = 4'b0;
        test_reset();
        test_single_event();
        test_back_to_back();
        test_overflow();
        test_fairness();
        test_hold_enable();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
